// File: rtl/iteration_frame_tx.sv
// iteration_frame_tx: buffers 102-bit sensor iteration records and streams each one as a 15-byte framed, checksummed packet.
module iteration_frame_tx #(
   parameter int DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                     clk_72MHz,
   input  logic                     reset,
   input  logic                     data_avl,
   input  logic [101:0]             sensor_iterations,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_count,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   typedef enum logic [1:0] {IDLE, SYNC, DATA, CHK} state_t;
   state_t state, state_n;
   logic [101:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [103:0] sh, sh_n;
   logic [7:0] acc, acc_n, data_n;
   logic [3:0] idx, idx_n;
   logic valid_n, hs, pop, push;
   assign hs = tx_valid && tx_ready;
   assign pop = (state == IDLE) && (fifo_level != '0);
   assign push = data_avl && ((fifo_level < FULL) || pop);
   assign busy = state != IDLE;
   always_comb begin
      state_n = state;
      sh_n = sh;
      acc_n = acc;
      idx_n = idx;
      data_n = tx_data;
      valid_n = tx_valid;
      case (state)
         IDLE: if (pop) begin
            sh_n = {2'b00, mem[rd_ptr]};
            acc_n = 8'h00;
            idx_n = 4'd0;
            data_n = SYNC_BYTE;
            valid_n = 1'b1;
            state_n = SYNC;
         end
         SYNC: if (hs) begin
            data_n = sh[103:96];
            state_n = DATA;
         end
         DATA: if (hs) begin
            acc_n = acc ^ sh[103:96];
            sh_n = {sh[95:0], 8'h00};
            idx_n = idx + 4'd1;
            data_n = (idx == 4'd12) ? acc_n : sh[95:88];
            state_n = (idx == 4'd12) ? CHK : DATA;
         end
         CHK: if (hs) begin
            valid_n = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_72MHz) begin
      if (reset) begin
         state <= IDLE;
         sh <= '0;
         acc <= 8'h00;
         idx <= 4'd0;
         tx_data <= 8'h00;
         tx_valid <= 1'b0;
      end else begin
         state <= state_n;
         sh <= sh_n;
         acc <= acc_n;
         idx <= idx_n;
         tx_data <= data_n;
         tx_valid <= valid_n;
      end
   end
   always_ff @(posedge clk_72MHz) begin
      if (push) mem[wr_ptr] <= sensor_iterations;
   end
   always_ff @(posedge clk_72MHz) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level <= '0;
         overflow <= 1'b0;
         drop_count <= 8'h00;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (data_avl && !push) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end
      end
   end
endmodule

// File: doc/iteration_frame_tx.md
Name: iteration_frame_tx

Overview:
- Downstream consumer of the triad sensor-iteration stream.
- Captures every 102-bit sensor_iterations record qualified by data_avl into a small FIFO.
- Serialises each record as a fixed 15-byte frame over a byte-wide valid/ready handshake to the host link (UART/SPI transmitter).
- Decouples bursty triad output from the slower byte link and reports dropped records.

Parameters:
DEPTH, 4, FIFO depth in records; power of two, minimum 2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk_72MHz  input  1  system clock, same domain as the triad manager.
reset  input  1  synchronous, active-high reset.
data_avl  input  1  one-cycle strobe; sensor_iterations valid this cycle.
sensor_iterations  input  102  record to buffer.
tx_data  output  8  frame byte.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  sink accepts byte when tx_valid && tx_ready.
fifo_level  output  $clog2(DEPTH)+1  records currently stored.
overflow  output  1  sticky: at least one record dropped since reset.
drop_count  output  8  dropped records, saturates at 255.
busy  output  1  high while a frame is in progress (FSM not IDLE).

Behaviour:
- Reset (synchronous, active high, clk_72MHz edge) values: tx_data=0, tx_valid=0, fifo_level=0, overflow=0, drop_count=0, busy=0, FSM=IDLE. FIFO pointers cleared and contents discarded.
- Reset asserted mid-frame aborts the frame immediately; tx_valid is low the next cycle.
- FIFO push:
  - Push occurs when data_avl=1 and either level<DEPTH or a pop occurs in the same cycle.
  - Otherwise the record is dropped: overflow<=1 and drop_count<=drop_count+1, saturating at 255.
  - Push and pop in the same cycle leave the level unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. fifo_level is a registered count.
- Frame format, 15 bytes, in order:
  - SYNC_BYTE.
  - D0..D12: the padded word P={2'b00, record}, with D0=P[103:96] through D12=P[7:0] (MSB first).
  - CHK = XOR of D0..D12.
- FSM states IDLE, SYNC, DATA, CHK:
  - IDLE: if level>0, pop the head record into a 104-bit shift register, clear the checksum accumulator and byte index, and go to SYNC. Next cycle tx_valid=1 with tx_data=SYNC_BYTE.
  - SYNC: on handshake, present D0 and go to DATA.
  - DATA: on each handshake, XOR the current byte into the checksum, shift left 8, and increment the index.
    - After the D12 handshake, present CHK (including D12) and go to CHK.
  - CHK: on handshake, drop tx_valid and go to IDLE.
- Back-to-back frames: IDLE consumes one cycle, so there is at least one tx_valid-low cycle between frames.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a handshake, except on reset.
  - tx_ready is ignored when tx_valid=0.
- Latency: data_avl sampled high at edge N with FIFO empty and FSM IDLE gives level=1 after edge N. Pop happens at edge N+1; tx_valid=1 with SYNC_BYTE after edge N+1. Minimum frame time with tx_ready tied high is 15 cycles plus 1 IDLE cycle.
- Simultaneous data_avl and pop when level=DEPTH: the record is accepted and not counted as dropped.
- busy=1 in SYNC, DATA and CHK.

Test Plan:
1. Single record, tx_ready=1.
   - Stimulus: sensor_iterations=102'h01_0203_0405_0607_0809_0A0B_0C0D with data_avl pulsed.
   - Required: bytes A5,01,02,…,0D,01 (CHK=01); tx_valid first high 2 cycles after the strobe; then tx_valid=0, busy=0, fifo_level=0.
2. Backpressure.
   - Stimulus: same record, tx_ready toggled 1 cycle high / 3 low.
   - Required: identical 15-byte sequence; tx_data stable through every stall.
3. Overflow, DEPTH=4, tx_ready=0.
   - Stimulus: 7 strobes of distinct records.
   - Required: the first record is popped, so the FIFO holds 4 and fifo_level=4; 2 dropped, drop_count=2, overflow=1.
   - Then tx_ready=1: exactly 5 frames emitted, in order of arrival.
4. Push at full coincident with pop.
   - Stimulus: level=4, FSM returns to IDLE in the same cycle as a data_avl strobe.
   - Required: level stays 4, drop_count unchanged.
5. Reset mid-frame.
   - Stimulus: assert reset after the 6th byte handshake.
   - Required: next cycle tx_valid=0, fifo_level=0, overflow=0, drop_count=0; a subsequent record produces a complete fresh frame starting with A5.
6. Saturation and pointer wrap.
   - Stimulus: 300 dropped records with tx_ready=0.
   - Required: drop_count=255.
   - Stimulus: 20 records at one per 20 cycles with tx_ready=1.
   - Required: 20 frames with correct CHK; pointers wrap without loss.
